// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// repeating it Repeat+1 times with optional idle gaps between frames.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [CNT_W-1:0] Repeat,
    input  logic [CNT_W-1:0] GapCycles,
    output logic             DataOut,
    output logic             DataValid,
    output logic             FrameStart,
    output logic             Busy,
    output logic             Done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] gap_rld;
    logic [CNT_W-1:0] gap_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pat_q;

    logic last_bit;
    logic start_go;
    logic shift_go;
    logic reload_go;

    always_comb begin
        last_bit  = (bit_cnt == LAST_BIT);
        start_go  = (state == IDLE) && Start && !Abort;
        shift_go  = (state == SHIFT) && !Abort && !last_bit;
        reload_go = !Abort &&
                    (((state == SHIFT) && last_bit && (frame_cnt != '0) && (gap_rld == '0)) ||
                     ((state == GAP) && (gap_cnt == CNT_W'(1))));
    end

    // shreg holds the bits still to be sent; the MSB already sits in DataOut
    always_ff @(posedge Clock) begin
        if (start_go) begin
            pat_q <= Pattern;
            shreg <= {Pattern[WIDTH-2:0], 1'b0};
        end else if (reload_go) begin
            shreg <= {pat_q[WIDTH-2:0], 1'b0};
        end else if (shift_go) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            gap_rld    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            DataOut    <= 1'b0;
            DataValid  <= 1'b0;
            FrameStart <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done       <= 1'b0;
            FrameStart <= 1'b0;
            if (Abort && (state != IDLE)) begin
                state     <= IDLE;
                frame_cnt <= '0;
                gap_rld   <= '0;
                gap_cnt   <= '0;
                bit_cnt   <= '0;
                DataOut   <= 1'b0;
                DataValid <= 1'b0;
                Busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_go) begin
                            state      <= SHIFT;
                            frame_cnt  <= Repeat;
                            gap_rld    <= GapCycles;
                            bit_cnt    <= '0;
                            DataOut    <= Pattern[WIDTH-1];
                            DataValid  <= 1'b1;
                            FrameStart <= 1'b1;
                            Busy       <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            DataOut <= shreg[WIDTH-1];
                        end else if (frame_cnt == '0) begin
                            state     <= DONE;
                            bit_cnt   <= '0;
                            DataOut   <= 1'b0;
                            DataValid <= 1'b0;
                            Done      <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt - 1'b1;
                            bit_cnt   <= '0;
                            if (gap_rld == '0) begin
                                DataOut    <= pat_q[WIDTH-1];
                                FrameStart <= 1'b1;
                            end else begin
                                state     <= GAP;
                                gap_cnt   <= gap_rld;
                                DataOut   <= 1'b0;
                                DataValid <= 1'b0;
                            end
                        end
                    end
                    GAP: begin
                        // gap_cnt counts the gap cycles still visible including this one
                        if (gap_cnt == CNT_W'(1)) begin
                            state      <= SHIFT;
                            gap_cnt    <= '0;
                            DataOut    <= pat_q[WIDTH-1];
                            DataValid  <= 1'b1;
                            FrameStart <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        DataOut   <= 1'b0;
                        DataValid <= 1'b0;
                        Busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed and random transfers compared cycle by
// cycle against a frame-list model of the expected serial stream.
module tb_serial_pattern_tx;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Abort;
    logic [7:0] Pattern;
    logic [3:0] Repeat;
    logic [3:0] GapCycles;
    logic       DataOut;
    logic       DataValid;
    logic       FrameStart;
    logic       Busy;
    logic       Done;

    logic [4:0] outs;
    logic [4:0] exp_q[$];
    int         vecs = 0;
    int         miscompares = 0;

    serial_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Pattern(Pattern), .Repeat(Repeat), .GapCycles(GapCycles),
        .DataOut(DataOut), .DataValid(DataValid), .FrameStart(FrameStart),
        .Busy(Busy), .Done(Done)
    );

    assign outs = {DataOut, DataValid, FrameStart, Busy, Done};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [4:0] obs,
                         input logic [4:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed={DO,DV,FS,BSY,DN}=%b expected=%b", tag, idx, obs, expv);
        end
    endtask

    // Expected per-cycle outputs of one whole transfer, starting at the first MSB cycle
    task automatic model_xfer(input logic [7:0] pat, input int rep, input int gap);
        for (int f = 0; f <= rep; f++) begin
            for (int b = 7; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, (b == 7), 1'b1, 1'b0});
            if (f < rep)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
    endtask

    task automatic run(input string tag, input logic [7:0] pat, input int rep,
                       input int gap, input bit scribble);
        exp_q.delete();
        model_xfer(pat, rep, gap);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        Pattern   = pat;
        Repeat    = 4'(rep);
        GapCycles = 4'(gap);
        Start     = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (scribble) begin
                Pattern   = 8'($urandom);
                Repeat    = 4'($urandom);
                GapCycles = 4'($urandom);
            end
            check(tag, i + 1, outs, exp_q[i]);
            step();
        end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
        Pattern = 8'h00; Repeat = 4'd0; GapCycles = 4'd0;
        step();
        check("reset_hold", 0, outs, 5'b00000);
        step();
        Reset = 1'b1;
        step();
        check("idle_after_reset", 0, outs, 5'b00000);

        // Asynchronous reset in the middle of a frame
        Pattern = 8'hFD; Start = 1'b1;
        step();
        Start = 1'b0;
        step(); step(); step();
        check("pre_reset_bit3", 4, outs, 5'b11010);
        #2 Reset = 1'b0;
        #1 check("async_reset", 0, outs, 5'b00000);
        step();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_post_reset", i, outs, 5'b00000);
        end

        run("single_FD", 8'hFD, 0, 0, 1'b0);
        run("rep2_FD", 8'hFD, 2, 0, 1'b0);
        run("gap3_A5", 8'hA5, 1, 3, 1'b0);
        run("gap15_3C", 8'h3C, 1, 15, 1'b1);

        // Start held high: transfers separated by DONE + IDLE; Pattern change mid-frame
        exp_q.delete();
        model_xfer(8'hC3, 0, 0); exp_q.push_back(5'b00000);
        model_xfer(8'h5A, 0, 0); exp_q.push_back(5'b00000);
        model_xfer(8'h5A, 0, 0); exp_q.push_back(5'b00000);
        Pattern = 8'hC3; Repeat = 4'd0; GapCycles = 4'd0; Start = 1'b1;
        step();
        for (int i = 0; i < exp_q.size(); i++) begin
            check("start_held", i + 1, outs, exp_q[i]);
            if (i + 1 == 3)  Pattern = 8'h5A;
            if (i + 1 == 21) Start = 1'b0;
            step();
        end

        // Abort during cycle 4 of a four-frame transfer
        exp_q.delete();
        model_xfer(8'h96, 3, 0);
        Pattern = 8'h96; Repeat = 4'd3; GapCycles = 4'd0; Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_pre", i + 1, outs, exp_q[i]);
            if (i == 3) Abort = 1'b1;
            step();
        end
        Abort = 1'b0;
        for (int i = 5; i < 10; i++) begin
            check("abort_post", i, outs, 5'b00000);
            step();
        end

        // Abort together with Start in IDLE
        Start = 1'b1; Abort = 1'b1;
        step();
        Start = 1'b0; Abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_start_idle", i, outs, 5'b00000);
            step();
        end

        // Random transfers with inputs scribbled while busy
        for (int t = 0; t < 12; t++)
            run("random", 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
